im_fetch_unit: RTL and testbench
================================

# im_fetch_unit

Parametrised instruction memory and fetch stage. It holds a register-file program store that software or the testbench can rewrite at runtime. Each request returns FETCH_WORDS consecutive words starting at `pc`, as a flat bus plus per-field nibble slices, registered with a valid flag. The block sits at the front of the IF stage, between the PC register and the decoder. It adds write-port loading, stall/hold, bounds faulting and write-to-read bypass.

## Interface
Parameters:
- ADDR_W, 16: width of `pc` and `wr_addr`.
- DEPTH, 16: number of words in the store (2..2^ADDR_W).
- WORD_W, 8: bits per word; must be a multiple of FIELD_W.
- FIELD_W, 4: width of one decoded field.
- FETCH_WORDS, 2: words returned per fetch (1..4).

Ports:
- clk, input, 1: the single clock; all state updates on its rising edge.
- rst, input, 1: reset, asynchronous and active-low.
- pc, input, ADDR_W: fetch start address.
- fetch_req, input, 1: request a fetch at `pc` this cycle.
- stall, input, 1: hold all outputs; has priority over `fetch_req`.
- wr_en, input, 1: write strobe.
- wr_addr, input, ADDR_W: write address.
- wr_data, input, WORD_W: write data.
- inst, output, FETCH_WORDS*WORD_W: fetched words; the word at `pc` occupies the MSBs.
- fields, output, FETCH_WORDS*WORD_W: the same bits as `inst`, viewed as FIELD_W slices; field 0 is the MSB slice.
- inst_valid, output, 1: `inst` holds the result of an accepted request.
- fault, output, 1: at least one word of the last accepted fetch was out of range.
- wr_err, output, 1: pulse, the last write targeted an address ≥ DEPTH and was dropped.

## Operation
- Store: DEPTH×WORD_W registers. Combinational read, synchronous write.
- Reset (rst=0, asynchronous):
  - every store word is set to 0, then the boot image is applied (see Configuration);
  - inst=0, inst_valid=0, fault=0, wr_err=0.
- Write: when wr_en=1 and wr_addr<DEPTH, store[wr_addr] ← wr_data at the edge. When wr_addr≥DEPTH, the store is unchanged and wr_err=1 for exactly one cycle.
- Fetch is accepted when fetch_req=1 and stall=0. At the edge:
  - word k (k=0..FETCH_WORDS-1) comes from address a=pc+k, computed at ADDR_W+1 bits, so there is no wrap-around.
  - If a≥DEPTH, word k reads 0 and fault=1 for this fetch. fault is 0 only if every word is in range.
- Bypass: if a write in the same cycle hits address a (wr_en=1, wr_addr=a<DEPTH), word k returns wr_data rather than the old contents.
- Idle (fetch_req=0, stall=0): inst holds its value, inst_valid←0, fault holds.
- Stall (stall=1): inst, inst_valid and fault all hold. Writes still execute.
- Per-cycle state machine:
  - IDLE→VALID on an accepted fetch.
  - VALID→VALID on an accepted fetch.
  - VALID→IDLE when fetch_req=0 and stall=0.
  - Any state holds under stall.
  - Any state returns to IDLE on reset.

## Timing
- Fetch latency is 1 cycle: request at edge n gives inst/inst_valid visible after edge n.
- Back-to-back requests give one result per cycle.
- A write at edge n is visible to a fetch at edge n through the bypass, and to the store from edge n+1.
- wr_err is registered and asserts the cycle after the offending write.
- Reset asserted mid-operation clears outputs immediately, without waiting for clk. The first accepted fetch after reset deasserts is serviced at the next edge.
- `fields` is a pure wire view of `inst` with no extra latency.

## Configuration
- IM_BOOT_IMAGE_EN defined:
  - on reset, word 0 = 0, and word k = {(10−k) as FIELD_W bits, k as FIELD_W bits}, zero-extended to WORD_W, for k=1..9 where k<DEPTH;
  - with the default widths this is 0x00,0x91,0x82,0x73,0x64,0x55,0x46,0x37,0x28,0x19.
- IM_BOOT_IMAGE_EN undefined: reset leaves every word 0, and the program must be loaded through the write port.

## Test plan
- Boot image, default parameters, IM_BOOT_IMAGE_EN defined: reset, then pc=1, fetch_req=1 → next cycle inst=0x9182, fields=9,1,8,2, inst_valid=1, fault=0.
- Bounds: pc=15, FETCH_WORDS=2 → inst=0x{store[15]}00, fault=1. Then pc=16 → inst=0x0000, fault=1. Then wr_addr=20 → store unchanged and wr_err pulses one cycle.
- Bypass: wr_en=1, wr_addr=3, wr_data=0xAB in the same cycle as a fetch with pc=2 → inst=0x82AB (boot image). A next fetch with pc=3 → inst=0xAB64.
- Stall: accepted fetch with pc=4, then stall=1 for 3 cycles while pc changes and fetch_req=1 → inst=0x6455 and inst_valid=1 held throughout. Releasing stall with fetch_req=0 → inst_valid=0 and inst held.
- Async reset mid-stream: drop rst between clock edges during back-to-back fetches → inst_valid=0, fault=0, inst=0 immediately, and the store is restored to the boot image.
- Macro off: reset, then a fetch at pc=1 → inst=0x0000. Write 0x5A to address 1, then fetch at pc=1 → inst=0x5A00.

Source files
------------

// File: rtl/im_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : im_fetch_unit
//  Description : Instruction memory plus IF-stage fetch register. Holds a
//                DEPTH x WORD_W register-file program store with a runtime
//                write port and returns FETCH_WORDS consecutive words per
//                accepted fetch. Out-of-range words read 0 and raise fault,
//                a same-cycle write to a fetched address is bypassed into the
//                result, and stall freezes every output.
//  Optional    : IM_BOOT_IMAGE_EN - when defined, reset loads a small boot
//                image into words 1..9; otherwise reset clears the store.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous reset, active low
//                pc         - fetch start address
//                fetch_req  - request a fetch at pc
//                stall      - hold outputs (wins over fetch_req)
//                wr_en/wr_addr/wr_data - store write port
//                inst       - fetched words, word at pc in the MSBs
//                fields     - inst viewed as FIELD_W slices (field 0 = MSBs)
//                inst_valid - inst holds the result of an accepted request
//                fault      - a word of the last accepted fetch was out of range
//                wr_err     - one-cycle pulse after a write to addr >= DEPTH
//  Revision    : 1.0 - initial release
// ============================================================================
module im_fetch_unit #(
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 16,
    parameter int WORD_W      = 8,
    parameter int FIELD_W     = 4,
    parameter int FETCH_WORDS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             pc,
    input  logic                          fetch_req,
    input  logic                          stall,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [WORD_W-1:0]             wr_data,
    output logic [FETCH_WORDS*WORD_W-1:0] inst,
    output logic [FETCH_WORDS*WORD_W-1:0] fields,
    output logic                          inst_valid,
    output logic                          fault,
    output logic                          wr_err
);

    localparam int              c_IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              c_INST_W = FETCH_WORDS * WORD_W;
    // Addresses are compared at ADDR_W+1 bits so pc+k never wraps.
    localparam logic [ADDR_W:0] c_DEPTH  = (ADDR_W+1)'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_VALID = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WORD_W-1:0]   r_mem [DEPTH];
    logic [c_INST_W-1:0] r_inst;
    logic                r_fault;
    logic                r_wr_err;

    logic                w_accept;
    logic                w_wr_ok;
    logic [c_INST_W-1:0] w_inst;
    logic                w_oob;
    logic [ADDR_W:0]     w_addr;
    logic [WORD_W-1:0]   w_word;

`ifdef IM_BOOT_IMAGE_EN
    // Boot word k = {10-k, k} as two FIELD_W fields, zero-extended.
    function automatic logic [WORD_W-1:0] f_boot_word(input int k);
        logic [2*FIELD_W-1:0] v;
        v = '0;
        if (k >= 1 && k <= 9) begin
            v = {FIELD_W'(10 - k), FIELD_W'(k)};
        end
        return WORD_W'(v);
    endfunction
`endif

    assign w_accept = fetch_req && !stall;
    assign w_wr_ok  = ({1'b0, wr_addr} < c_DEPTH);

    // ------------------------------------------------------------------
    // Program store: asynchronous reset to the boot image, sync write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
`ifdef IM_BOOT_IMAGE_EN
                r_mem[k] <= f_boot_word(k);
`else
                r_mem[k] <= '0;
`endif
            end
        end else if (wr_en && w_wr_ok) begin
            r_mem[wr_addr[c_IDX_W-1:0]] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Fetch assembly: word k from pc+k, zero when out of range, and the
    // same-cycle write data when the write hits that address.
    // ------------------------------------------------------------------
    always_comb begin
        w_inst = '0;
        w_oob  = 1'b0;
        w_addr = '0;
        w_word = '0;
        for (int k = 0; k < FETCH_WORDS; k++) begin
            w_addr = {1'b0, pc} + (ADDR_W+1)'(k);
            if (w_addr >= c_DEPTH) begin
                w_oob  = 1'b1;
                w_word = '0;
            end else if (wr_en && ({1'b0, wr_addr} == w_addr)) begin
                w_word = wr_data;
            end else begin
                w_word = r_mem[w_addr[c_IDX_W-1:0]];
            end
            w_inst[(FETCH_WORDS-1-k)*WORD_W +: WORD_W] = w_word;
        end
    end

    // ------------------------------------------------------------------
    // Valid-tracking state machine.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!stall) begin
            if (fetch_req) begin
                w_state_nxt = S_VALID;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers. inst and fault only change on an accepted fetch.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inst   <= '0;
            r_fault  <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= wr_en && !w_wr_ok;
            if (w_accept) begin
                r_inst  <= w_inst;
                r_fault <= w_oob;
            end
        end
    end

    assign inst       = r_inst;
    assign fields     = r_inst;
    assign inst_valid = (r_state == S_VALID);
    assign fault      = r_fault;
    assign wr_err     = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_im_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_im_fetch_unit
//  Description : Scoreboard bench for im_fetch_unit. A driver applies
//                directed and random stimulus on the falling edge, advances a
//                behavioural model of the instruction memory and pushes the
//                expected outputs; a monitor pops and compares after every
//                rising edge. Boot image expectations follow IM_BOOT_IMAGE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_im_fetch_unit;

    localparam int ADDR_W = 16;
    localparam int DEPTH  = 16;
    localparam int WORD_W = 8;
    localparam int FIELD_W = 4;
    localparam int FW     = 2;
    localparam int IW     = FW * WORD_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] pc = '0;
    logic              fetch_req = 1'b0;
    logic              stall = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [WORD_W-1:0] wr_data = '0;
    logic [IW-1:0]     inst;
    logic [IW-1:0]     fields;
    logic              inst_valid;
    logic              fault;
    logic              wr_err;

    always #5 clk = ~clk;

    im_fetch_unit #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WORD_W(WORD_W),
        .FIELD_W(FIELD_W), .FETCH_WORDS(FW)
    ) dut (
        .clk(clk), .rst(rst), .pc(pc), .fetch_req(fetch_req), .stall(stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .inst(inst), .fields(fields), .inst_valid(inst_valid),
        .fault(fault), .wr_err(wr_err)
    );

    typedef struct packed {
        logic [IW-1:0] inst;
        logic          valid;
        logic          fault;
        logic          wr_err;
    } exp_t;

    exp_t q[$];
    bit   started = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    logic [WORD_W-1:0] m_mem [DEPTH];
    logic [IW-1:0]     m_inst;
    bit                m_v, m_f, m_we;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
`ifdef IM_BOOT_IMAGE_EN
        for (int k = 1; k <= 9; k++)
            if (k < DEPTH) m_mem[k] = WORD_W'(((10 - k) << FIELD_W) | k);
`endif
        m_inst = '0;
        m_v    = 1'b0;
        m_f    = 1'b0;
        m_we   = 1'b0;
    endfunction

    // One clock cycle of stimulus plus the model's view of the next edge.
    task automatic cycle(input bit r, input bit req, input bit st, input int p,
                         input bit we, input int wa, input int wd);
        logic [IW-1:0]     ni;
        logic [WORD_W-1:0] w;
        bit                nf;
        exp_t              e;
        @(negedge clk);
        rst       = r;
        fetch_req = req;
        stall     = st;
        pc        = ADDR_W'(p);
        wr_en     = we;
        wr_addr   = ADDR_W'(wa);
        wr_data   = WORD_W'(wd);
        if (!r) begin
            model_reset();
        end else begin
            ni = '0;
            nf = 1'b0;
            for (int k = 0; k < FW; k++) begin
                int a;
                a = p + k;
                if (a >= DEPTH) begin
                    w  = '0;
                    nf = 1'b1;
                end else if (we && wa == a) begin
                    w = WORD_W'(wd);
                end else begin
                    w = m_mem[a];
                end
                ni = (ni << WORD_W) | IW'(w);
            end
            if (!st) begin
                if (req) begin
                    m_inst = ni;
                    m_v    = 1'b1;
                    m_f    = nf;
                end else begin
                    m_v = 1'b0;
                end
            end
            m_we = we && (wa >= DEPTH);
            if (we && wa < DEPTH) m_mem[wa] = WORD_W'(wd);
        end
        e.inst   = m_inst;
        e.valid  = m_v;
        e.fault  = m_f;
        e.wr_err = m_we;
        q.push_back(e);
        started = 1'b1;
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1,
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < 2,
                  int'($urandom_range(0, DEPTH + 3)),
                  $urandom_range(0, 9) < 4,
                  int'($urandom_range(0, DEPTH + 4)),
                  int'($urandom_range(0, 255)));
        end
    endtask

    // Monitor: compare DUT outputs after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                if (started) chk("queue_underflow", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                chk("inst", 64'(inst), 64'(e.inst));
                chk("fields", 64'(fields), 64'(e.inst));
                chk("inst_valid", 64'(inst_valid), 64'(e.valid));
                chk("fault", 64'(fault), 64'(e.fault));
                chk("wr_err", 64'(wr_err), 64'(e.wr_err));
            end
        end
    end

    // Driver
    initial begin
        model_reset();
        cycle(1'b0, 0, 0, 0, 0, 0, 0);
        cycle(1'b0, 0, 0, 0, 0, 0, 0);
        cycle(1'b1, 0, 0, 0, 0, 0, 0);
        // Boot image fetch and bounds
        cycle(1'b1, 1, 0, 1, 0, 0, 0);
        cycle(1'b1, 1, 0, 15, 0, 0, 0);
        cycle(1'b1, 1, 0, 16, 0, 0, 0);
        cycle(1'b1, 0, 0, 0, 1, 20, 8'h77);
        cycle(1'b1, 0, 0, 0, 0, 0, 0);
        cycle(1'b1, 1, 0, 15, 0, 0, 0);
        // Write-to-read bypass, then the stored value
        cycle(1'b1, 1, 0, 2, 1, 3, 8'hAB);
        cycle(1'b1, 1, 0, 3, 0, 0, 0);
        // Stall holds everything while pc moves; writes still land
        cycle(1'b1, 1, 0, 4, 0, 0, 0);
        cycle(1'b1, 1, 1, 7, 0, 0, 0);
        cycle(1'b1, 1, 1, 9, 1, 9, 8'hC3);
        cycle(1'b1, 1, 1, 11, 0, 0, 0);
        cycle(1'b1, 0, 0, 5, 0, 0, 0);
        cycle(1'b1, 1, 0, 8, 0, 0, 0);
        // Load through the write port, then fetch it
        cycle(1'b1, 0, 0, 0, 1, 1, 8'h5A);
        cycle(1'b1, 1, 0, 1, 0, 0, 0);
        cycle(1'b1, 1, 0, 14, 1, 15, 8'hE1);
        rand_cycles(500);
        // Back-to-back fetches, then reset dropped between clock edges
        cycle(1'b1, 1, 0, 3, 0, 0, 0);
        cycle(1'b1, 1, 0, 15, 0, 0, 0);
        cycle(1'b1, 1, 0, 6, 1, 6, 8'h3C);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_inst", 64'(inst), 64'd0);
        chk("async_valid", 64'(inst_valid), 64'd0);
        chk("async_fault", 64'(fault), 64'd0);
        chk("async_wr_err", 64'(wr_err), 64'd0);
        model_reset();
        cycle(1'b0, 1, 0, 2, 0, 0, 0);
        cycle(1'b1, 1, 0, 1, 0, 0, 0);
        cycle(1'b1, 1, 0, 5, 0, 0, 0);
        cycle(1'b1, 1, 0, 6, 0, 0, 0);
        rand_cycles(200);
        cycle(1'b1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        n_errors++;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
